// File: rtl/pc_redirect_module_if.sv
// rtl/pc_redirect_module_if.sv - fetch-stage redirect/PC bus between pipeline control and the PC unit
interface pc_redirect_module_if;
    logic        PC_SEL;
    logic [31:0] BRANCH_TARGET;
    logic        HAZARD_STALL;
    logic        IMEM_BUSYWAIT;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        IMEM_READ;
    logic        FLUSH;
    logic        MISALIGN;
    logic [15:0] REDIRECT_COUNT;

    modport master (
        output PC_SEL, BRANCH_TARGET, HAZARD_STALL, IMEM_BUSYWAIT,
        input  PC, PC_PLUS4, IMEM_READ, FLUSH, MISALIGN, REDIRECT_COUNT
    );

    modport slave (
        input  PC_SEL, BRANCH_TARGET, HAZARD_STALL, IMEM_BUSYWAIT,
        output PC, PC_PLUS4, IMEM_READ, FLUSH, MISALIGN, REDIRECT_COUNT
    );
endinterface

// File: rtl/pc_redirect_module.sv
// rtl/pc_redirect_module.sv - program counter with branch redirect, pending target under busywait and flush timing
module pc_redirect_module #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_LEN    = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    pc_redirect_module_if.slave bus
);

    typedef enum logic [1:0] {RUN, PENDING, FLUSHING} state_t;

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_LEN);

    state_t      state, state_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] pending_q, pending_nx;
    logic [2:0]  cnt_q, cnt_nx;
    logic [15:0] count_q, count_nx;
    logic        misalign_q, misalign_nx;
    logic        apply;
    logic [31:0] apply_target;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= RUN;
            pc_q       <= RESET_VECTOR;
            pending_q  <= 32'h0;
            cnt_q      <= 3'd0;
            count_q    <= 16'h0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_q       <= pc_nx;
            pending_q  <= pending_nx;
            cnt_q      <= cnt_nx;
            count_q    <= count_nx;
            misalign_q <= misalign_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc_q;
        pending_nx   = pending_q;
        cnt_nx       = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        count_nx     = count_q;
        misalign_nx  = 1'b0;
        // A fresh PC_SEL supersedes any pending target (last one wins)
        apply_target = bus.PC_SEL ? bus.BRANCH_TARGET : pending_q;
        apply        = !bus.IMEM_BUSYWAIT && (bus.PC_SEL || state == PENDING);

        if (apply) begin
            pc_nx       = {apply_target[31:2], 2'b00};
            state_nx    = FLUSHING;
            cnt_nx      = FLUSH_CNT;
            misalign_nx = |apply_target[1:0];
            if (count_q != 16'hFFFF)
                count_nx = count_q + 16'd1;
        end else if (bus.PC_SEL) begin
            pending_nx = bus.BRANCH_TARGET;
            state_nx   = PENDING;
        end else if (state != PENDING) begin
            if (!bus.HAZARD_STALL && !bus.IMEM_BUSYWAIT)
                pc_nx = pc_q + 32'd4;
            if (cnt_nx == 3'd0)
                state_nx = RUN;
        end
    end

    assign bus.PC             = pc_q;
    assign bus.PC_PLUS4       = pc_q + 32'd4;
    assign bus.IMEM_READ      = !RESET;
    assign bus.FLUSH          = (cnt_q != 3'd0);
    assign bus.MISALIGN       = misalign_q;
    assign bus.REDIRECT_COUNT = count_q;

endmodule

// File: tb/tb_pc_redirect_module.sv
// tb/tb_pc_redirect_module.sv - directed self-checking bench for pc_redirect_module
module tb_pc_redirect_module;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    pc_redirect_module_if bus();

    pc_redirect_module #(.RESET_VECTOR(32'h0000_0000), .FLUSH_LEN(2)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic sel, input logic [31:0] tgt, input logic hz, input logic busy);
        bus.PC_SEL        = sel;
        bus.BRANCH_TARGET = tgt;
        bus.HAZARD_STALL  = hz;
        bus.IMEM_BUSYWAIT = busy;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        RESET = 1'b1;
        step();
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_flush", {31'h0, bus.FLUSH}, 32'h0);
        chk("rst_misalign", {31'h0, bus.MISALIGN}, 32'h0);
        chk("rst_count", {16'h0, bus.REDIRECT_COUNT}, 32'h0);
        chk("rst_imem_read", {31'h0, bus.IMEM_READ}, 32'h0);
        chk("rst_pc_plus4", bus.PC_PLUS4, 32'h4);

        RESET = 1'b0;
        step(); chk("free1_pc", bus.PC, 32'h4); chk("free1_flush", {31'h0, bus.FLUSH}, 32'h0);
        chk("free_imem_read", {31'h0, bus.IMEM_READ}, 32'h1);
        step(); chk("free2_pc", bus.PC, 32'h8); chk("free2_flush", {31'h0, bus.FLUSH}, 32'h0);
        step(); chk("free3_pc", bus.PC, 32'hC); chk("free3_flush", {31'h0, bus.FLUSH}, 32'h0);
        step(); chk("free4_pc", bus.PC, 32'h10);

        // Simple redirect
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step();
        chk("br_pc", bus.PC, 32'h100);
        chk("br_flush1", {31'h0, bus.FLUSH}, 32'h1);
        chk("br_count", {16'h0, bus.REDIRECT_COUNT}, 32'h1);
        chk("br_misalign", {31'h0, bus.MISALIGN}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("br_pc2", bus.PC, 32'h104); chk("br_flush2", {31'h0, bus.FLUSH}, 32'h1);
        step(); chk("br_pc3", bus.PC, 32'h108); chk("br_flush3", {31'h0, bus.FLUSH}, 32'h0);

        // Redirect while instruction memory is busy
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        step(); chk("busy1_pc", bus.PC, 32'h108); chk("busy1_count", {16'h0, bus.REDIRECT_COUNT}, 32'h1);
        chk("busy1_flush", {31'h0, bus.FLUSH}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step(); chk("busy2_pc", bus.PC, 32'h108);
        step(); chk("busy3_pc", bus.PC, 32'h108);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("pend_apply_pc", bus.PC, 32'h200); chk("pend_flush1", {31'h0, bus.FLUSH}, 32'h1);
        chk("pend_count", {16'h0, bus.REDIRECT_COUNT}, 32'h2);
        step(); chk("pend_pc2", bus.PC, 32'h204); chk("pend_flush2", {31'h0, bus.FLUSH}, 32'h1);
        step(); chk("pend_pc3", bus.PC, 32'h208); chk("pend_flush3", {31'h0, bus.FLUSH}, 32'h0);

        // Redirect wins over hazard stall; stall alone holds
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        step(); chk("hz_br_pc", bus.PC, 32'h40); chk("hz_br_count", {16'h0, bus.REDIRECT_COUNT}, 32'h3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step(); chk("hz_hold_pc", bus.PC, 32'h40); chk("hz_flush_ungated", {31'h0, bus.FLUSH}, 32'h1);
        step(); chk("hz_hold_pc2", bus.PC, 32'h40); chk("hz_flush_done", {31'h0, bus.FLUSH}, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("hz_release_pc", bus.PC, 32'h44);

        // Misaligned target, then redirect during flush
        drive(1'b1, 32'h103, 1'b0, 1'b0);
        step(); chk("mis_pc", bus.PC, 32'h100); chk("mis_pulse", {31'h0, bus.MISALIGN}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("mis_pc2", bus.PC, 32'h104); chk("mis_clear", {31'h0, bus.MISALIGN}, 32'h0);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step(); chk("reld_pc", bus.PC, 32'h300); chk("reld_flush1", {31'h0, bus.FLUSH}, 32'h1);
        chk("reld_count", {16'h0, bus.REDIRECT_COUNT}, 32'h5);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("reld_flush2", {31'h0, bus.FLUSH}, 32'h1);
        step(); chk("reld_flush3", {31'h0, bus.FLUSH}, 32'h0); chk("reld_pc3", bus.PC, 32'h308);

        // Pending target overwritten by a newer one
        drive(1'b1, 32'h400, 1'b0, 1'b1);
        step(); chk("ovw_hold1", bus.PC, 32'h308);
        drive(1'b1, 32'h500, 1'b0, 1'b1);
        step(); chk("ovw_hold2", bus.PC, 32'h308);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("ovw_pc", bus.PC, 32'h500); chk("ovw_count", {16'h0, bus.REDIRECT_COUNT}, 32'h6);
        step(); step();

        // Reset while pending discards the target
        drive(1'b1, 32'h600, 1'b0, 1'b1);
        step(); chk("rp_hold", bus.PC, 32'h508);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        RESET = 1'b1;
        step(); chk("rp_pc", bus.PC, 32'h0); chk("rp_count", {16'h0, bus.REDIRECT_COUNT}, 32'h0);
        chk("rp_imem_read", {31'h0, bus.IMEM_READ}, 32'h0);
        RESET = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("rp_after_pc", bus.PC, 32'h4); chk("rp_after_flush", {31'h0, bus.FLUSH}, 32'h0);
        step(); chk("rp_after_pc2", bus.PC, 32'h8);

        // 32-bit wrap of the increment
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(); chk("wrap_pc", bus.PC, 32'hFFFF_FFFC); chk("wrap_plus4", bus.PC_PLUS4, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("wrap_next", bus.PC, 32'h0);

        // Saturation of the redirect counter
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) @(posedge CLK);
        @(negedge CLK);
        chk("sat_count", {16'h0, bus.REDIRECT_COUNT}, 32'h0000_FFFF);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk("sat_hold", {16'h0, bus.REDIRECT_COUNT}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_redirect_module.md
PC_REDIRECT_MODULE -- requirements
Module: pc_redirect_module

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_LEN, default 2: number of cycles FLUSH stays high per redirect; legal range 1..7.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port PC_SEL, input, 1: branch/jump taken, from the branch/jump detect stage.
REQ-006 SHALL have port BRANCH_TARGET, input, 32: redirect target address, valid when PC_SEL=1.
REQ-007 SHALL have port HAZARD_STALL, input, 1: load-use stall request from the hazard unit.
REQ-008 SHALL have port IMEM_BUSYWAIT, input, 1: instruction memory has not completed the current fetch.
REQ-009 SHALL have port PC, output, 32: current fetch address, registered.
REQ-010 SHALL have port PC_PLUS4, output, 32: PC+4, combinational from PC.
REQ-011 SHALL have port IMEM_READ, output, 1: fetch request.
REQ-012 SHALL have port FLUSH, output, 1: clear the IF/ID and ID/EX pipeline registers.
REQ-013 SHALL have port MISALIGN, output, 1: one-cycle pulse for a redirect target with bits [1:0] not equal to 00.
REQ-014 SHALL have port REDIRECT_COUNT, output, 16: count of applied redirects, saturating.

Function
REQ-015 SHALL implement a state machine with three states: RUN, PENDING and FLUSHING.
REQ-016 Priority of updates to PC on each edge SHALL be: RESET, then applied redirect, then hold, then increment.
REQ-017 RUN state, PC_SEL=1 and IMEM_BUSYWAIT=0: on the edge, PC <= {BRANCH_TARGET[31:2],2'b00}; the state goes to FLUSHING and the flush counter loads FLUSH_LEN.
REQ-018 RUN state, PC_SEL=1 and IMEM_BUSYWAIT=1: PC holds and BRANCH_TARGET is latched into the pending register; the state goes to PENDING.
REQ-019 PENDING state: PC holds while IMEM_BUSYWAIT=1; on the first edge with IMEM_BUSYWAIT=0, PC <= pending target and the state goes to FLUSHING with the counter loaded to FLUSH_LEN.
REQ-020 PENDING state with a new PC_SEL=1: the pending register is overwritten with the newer BRANCH_TARGET (last one wins).
REQ-021 PC_SEL=1 SHALL override HAZARD_STALL; the stalled instruction belongs to the wrong path.
REQ-022 With no redirect, PC SHALL hold while HAZARD_STALL=1 or IMEM_BUSYWAIT=1; otherwise PC <= PC+4, with 32-bit wrap (32'hFFFF_FFFC goes to 32'h0000_0000).
REQ-023 FLUSH SHALL equal (flush counter != 0); the counter decrements once per cycle while nonzero and is not gated by the stall inputs.
REQ-024 FLUSHING state: when the counter reaches 0, return to RUN; a redirect during FLUSHING follows REQ-017/REQ-018 and reloads the counter to FLUSH_LEN.
REQ-025 Redirect latency SHALL be one edge: PC_SEL sampled at edge k gives PC = target and FLUSH=1 after edge k (when IMEM_BUSYWAIT=0).
REQ-026 MISALIGN SHALL pulse for exactly one cycle after the edge that applies a target with bits [1:0] != 00.
REQ-027 REDIRECT_COUNT SHALL increment on every applied redirect (not on latching) and saturate at 16'hFFFF.
REQ-028 IMEM_READ SHALL be 1 in every cycle except the reset cycle.

Reset
REQ-029 RESET=1 at an edge SHALL set: PC=RESET_VECTOR, state=RUN, flush counter=0, FLUSH=0, MISALIGN=0, REDIRECT_COUNT=0, pending register=0.
REQ-030 RESET SHALL override all concurrent inputs, and a reset during PENDING SHALL discard the latched target.
REQ-031 IMEM_READ SHALL be 0 while RESET=1.

Verification
REQ-032 Reset then 3 free cycles -> PC steps 0x0, 0x4, 0x8, 0xC; FLUSH=0 throughout.
REQ-033 At PC=0x10, PC_SEL=1 with BRANCH_TARGET=0x100 -> next PC=0x100, FLUSH=1 for 2 cycles, REDIRECT_COUNT=1.
REQ-034 IMEM_BUSYWAIT=1 for 3 cycles, with PC_SEL=1 and target 0x200 in the first cycle -> PC holds, then becomes 0x200 on the first non-busy edge, then FLUSH=1 for 2 cycles.
REQ-035 HAZARD_STALL=1 together with PC_SEL=1 and target 0x40 -> PC=0x40 (redirect wins); HAZARD_STALL=1 alone -> PC holds.
REQ-036 Target 0x103 -> PC=0x100 and MISALIGN pulses for 1 cycle; a second redirect during FLUSH -> counter reloads and FLUSH stays high for 2 more cycles.
REQ-037 Assert RESET during PENDING -> PC=RESET_VECTOR and the latched target is never applied.
